// File: rtl/min_index_frame_reducer.sv
// -----------------------------------------------------------------------------
// min_index_frame_reducer
//
// Reduces a stream of per-sample (index, value) winners from an upstream
// min-index stage into a single per-frame minimum. It reports the value, its
// vector index, its position in the frame and the frame length.
//
// A frame closes on a valid sample carrying in_last, or on the sample that
// brings the count to FRAME_LEN. The result lands in a one-entry output
// register with a valid/ready handshake. The input side is never stalled.
// A frame that closes while the output register is full and not being
// accepted is dropped, and the sticky overrun flag records the drop.
//
// Ports
//   clk        : sole clock, rising edge
//   rstn       : synchronous active-low reset
//   in_valid   : input sample strobe (no backpressure)
//   in_index   : winning vector index of the sample
//   in_c       : winning value of the sample (compared as unsigned bits)
//   in_last    : final sample of the frame, qualified by in_valid
//   out_valid  : frame result held and presented
//   out_ready  : downstream accepts the result when out_valid is also high
//   out_index  : index of the frame minimum
//   out_c      : frame minimum value
//   out_pos    : 0-based in-frame position of the minimum sample
//   out_count  : number of samples in the frame
//   overrun    : sticky, set when a frame result was dropped
// -----------------------------------------------------------------------------
module min_index_frame_reducer #(
  parameter int BITS       = 16,
  parameter int INDEX_BITS = 4,
  parameter int POS_BITS   = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [INDEX_BITS-1:0] in_index,
  input  logic [BITS-1:0]       in_c,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDEX_BITS-1:0] out_index,
  output logic [BITS-1:0]       out_c,
  output logic [POS_BITS-1:0]   out_pos,
  output logic [POS_BITS:0]     out_count,
  output logic                  overrun
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [POS_BITS:0] FRAME_LEN_C = (POS_BITS + 1)'(FRAME_LEN);
  localparam logic [POS_BITS:0] ONE_C       = {{POS_BITS{1'b0}}, 1'b1};

  state_t                  state_r;
  logic [BITS-1:0]         min_c_r;
  logic [INDEX_BITS-1:0]   min_index_r;
  logic [POS_BITS-1:0]     min_pos_r;
  logic [POS_BITS:0]       count_r;

  logic [BITS-1:0]         next_c_s;
  logic [INDEX_BITS-1:0]   next_index_s;
  logic [POS_BITS-1:0]     next_pos_s;
  logic [POS_BITS:0]       next_count_s;
  logic                    terminate_s;
  logic                    accept_s;
  logic                    write_s;
  logic                    drop_s;

  // Running minimum as it would look after absorbing the current sample, plus
  // the frame-termination and output-register decisions.
  always_comb begin
    next_c_s     = min_c_r;
    next_index_s = min_index_r;
    next_pos_s   = min_pos_r;
    next_count_s = count_r;
    if (state_r == IDLE) begin
      next_c_s     = in_c;
      next_index_s = in_index;
      next_pos_s   = {POS_BITS{1'b0}};
      next_count_s = ONE_C;
    end else begin
      next_count_s = count_r + ONE_C;
      // Strictly smaller only: on a tie the earlier sample is kept.
      // count_r is below FRAME_LEN here, so it fits in POS_BITS.
      if (in_c < min_c_r) begin
        next_c_s     = in_c;
        next_index_s = in_index;
        next_pos_s   = count_r[POS_BITS-1:0];
      end else begin
        next_c_s     = min_c_r;
        next_index_s = min_index_r;
        next_pos_s   = min_pos_r;
      end
    end

    if (in_valid) begin
      terminate_s = in_last || (next_count_s == FRAME_LEN_C);
    end else begin
      terminate_s = 1'b0;
    end

    accept_s = out_valid && out_ready;
    // The register is free if it is empty or is being drained this cycle.
    write_s  = terminate_s && (!out_valid || out_ready);
    drop_s   = terminate_s && out_valid && !out_ready;
  end

  // Frame FSM, running minimum and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      min_c_r     <= {BITS{1'b0}};
      min_index_r <= {INDEX_BITS{1'b0}};
      min_pos_r   <= {POS_BITS{1'b0}};
      count_r     <= {(POS_BITS + 1){1'b0}};
      out_valid   <= 1'b0;
      out_index   <= {INDEX_BITS{1'b0}};
      out_c       <= {BITS{1'b0}};
      out_pos     <= {POS_BITS{1'b0}};
      out_count   <= {(POS_BITS + 1){1'b0}};
      overrun     <= 1'b0;
    end else begin
      if (in_valid) begin
        if (terminate_s) begin
          state_r <= IDLE;
        end else begin
          state_r     <= ACCUM;
          min_c_r     <= next_c_s;
          min_index_r <= next_index_s;
          min_pos_r   <= next_pos_s;
          count_r     <= next_count_s;
        end
      end else begin
        state_r <= state_r;
      end

      if (write_s) begin
        out_valid <= 1'b1;
        out_index <= next_index_s;
        out_c     <= next_c_s;
        out_pos   <= next_pos_s;
        out_count <= next_count_s;
      end else if (accept_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end

      if (drop_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_min_index_frame_reducer.sv
module tb_min_index_frame_reducer;

  localparam int FRAME_LEN = 16;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [3:0]  in_index;
  logic [15:0] in_c;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [15:0] out_c;
  logic [7:0]  out_pos;
  logic [8:0]  out_count;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // Reference model: samples of the open frame plus the expected output state.
  int          q_c[$];
  int          q_idx[$];
  logic        exp_valid;
  logic        exp_ovr;
  logic [3:0]  exp_index;
  logic [15:0] exp_c;
  logic [7:0]  exp_pos;
  logic [8:0]  exp_count;

  min_index_frame_reducer #(
    .BITS(16), .INDEX_BITS(4), .POS_BITS(8), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_index(in_index),
    .in_c(in_c), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_c(out_c),
    .out_pos(out_pos), .out_count(out_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int best;
    logic acc;
    if (!rstn) begin
      q_c.delete(); q_idx.delete();
      exp_valid = 1'b0; exp_ovr = 1'b0;
      exp_index = 4'd0; exp_c = 16'd0; exp_pos = 8'd0; exp_count = 9'd0;
    end else begin
      acc = exp_valid && out_ready;
      if (in_valid) begin
        q_c.push_back(int'(in_c));
        q_idx.push_back(int'(in_index));
      end
      if (in_valid && (in_last || q_c.size() == FRAME_LEN)) begin
        best = 0;
        for (int i = 1; i < q_c.size(); i++) if (q_c[i] < q_c[best]) best = i;
        if (!exp_valid || out_ready) begin
          exp_valid = 1'b1;
          exp_c     = 16'(q_c[best]);
          exp_index = 4'(q_idx[best]);
          exp_pos   = 8'(best);
          exp_count = 9'(q_c.size());
        end else begin
          exp_ovr = 1'b1;
        end
        q_c.delete(); q_idx.delete();
      end else if (acc) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [3:0] idx, input logic [15:0] c,
                      input logic last, input logic rdy, input logic rn);
    in_valid = v; in_index = idx; in_c = c; in_last = last;
    out_ready = rdy; rstn = rn;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 4'd3, 16'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
    checks++; if ({out_index, out_c, out_pos, out_count} !== 37'd0) begin errors++;
      $display("FAIL reset_data got idx=%0d c=%0d pos=%0d cnt=%0d want all 0", out_index, out_c, out_pos, out_count); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] cs[4] = '{16'd9, 16'd4, 16'd7, 16'd4};
    logic [3:0]  is[4] = '{4'd1, 4'd2, 4'd3, 4'd5};
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, is[i], cs[i], (i == 3) ? 1'b1 : 1'b0, 1'b1, 1'b1);
      if (i < 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b want=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
    checks++; if (out_c !== 16'd4 || out_index !== 4'd2) begin errors++;
      $display("FAIL basic_min got c=%0d idx=%0d want c=4 idx=2", out_c, out_index); end
    checks++; if (out_pos !== 8'd1 || out_count !== 9'd4) begin errors++;
      $display("FAIL basic_pos got pos=%0d cnt=%0d want pos=1 cnt=4", out_pos, out_count); end
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_single_sample();
    step(1'b1, 4'd7, 16'h3C00, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_c !== 16'h3C00 || out_index !== 4'd7) begin errors++;
      $display("FAIL single_data got v=%0b c=%h idx=%0d want v=1 c=3c00 idx=7", out_valid, out_c, out_index); end
    checks++; if (out_pos !== 8'd0 || out_count !== 9'd1) begin errors++;
      $display("FAIL single_pos got pos=%0d cnt=%0d want pos=0 cnt=1", out_pos, out_count); end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < FRAME_LEN; i++)
      step(1'b1, 4'(i), 16'(200 - i), 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_count !== 9'd16 || out_pos !== 8'd15) begin errors++;
      $display("FAIL full_auto got v=%0b cnt=%0d pos=%0d want v=1 cnt=16 pos=15", out_valid, out_count, out_pos); end
    checks++; if (out_c !== 16'd185 || out_index !== 4'd15) begin errors++;
      $display("FAIL full_min got c=%0d idx=%0d want c=185 idx=15", out_c, out_index); end
    step(1'b1, 4'd9, 16'd500, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_pos !== 8'd0 || out_count !== 9'd1 || out_c !== 16'd500) begin errors++;
      $display("FAIL full_next got v=%0b pos=%0d cnt=%0d c=%0d want v=1 pos=0 cnt=1 c=500", out_valid, out_pos, out_count, out_c); end
  endtask

  task automatic test_overrun();
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd1, 16'd30, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 16'd20, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'd3, 16'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd4, 16'd2, 1'b1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_c !== 16'd20 || out_index !== 4'd2 || out_pos !== 8'd1 || out_count !== 9'd2) begin errors++;
      $display("FAIL ovr_held got v=%0b c=%0d idx=%0d pos=%0d cnt=%0d want v=1 c=20 idx=2 pos=1 cnt=2",
               out_valid, out_c, out_index, out_pos, out_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%0b want=1", overrun); end
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_handshake got=%0b want=0", out_valid); end
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b1) begin errors++;
      $display("FAIL ovr_sticky got v=%0b ovr=%0b want v=0 ovr=1", out_valid, overrun); end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 4'd1, 16'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 16'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 16'd3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd4, 16'd5, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd5, 16'd6, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_count !== 9'd2 || out_c !== 16'd5 || out_pos !== 8'd0) begin errors++;
      $display("FAIL rst_mid got v=%0b cnt=%0d c=%0d pos=%0d want v=1 cnt=2 c=5 pos=0", out_valid, out_count, out_c, out_pos); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr got=%0b want=0", overrun); end
  endtask

  task automatic test_gap_accept();
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd1, 16'd10, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 16'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 4'd2, 16'd3, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd3, 16'd3, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_count !== 9'd3 || out_pos !== 8'd1 || out_index !== 4'd2) begin errors++;
      $display("FAIL gap_frame got v=%0b cnt=%0d pos=%0d idx=%0d want v=1 cnt=3 pos=1 idx=2", out_valid, out_count, out_pos, out_index); end
    step(1'b1, 4'd4, 16'd8, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd6, 16'd2, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_c !== 16'd2 || out_count !== 9'd2 || out_pos !== 8'd1 || out_index !== 4'd6) begin errors++;
      $display("FAIL gap_same_cycle got v=%0b c=%0d cnt=%0d pos=%0d idx=%0d want v=1 c=2 cnt=2 pos=1 idx=6",
               out_valid, out_c, out_count, out_pos, out_index); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL gap_ovr got=%0b want=0", overrun); end
  endtask

  task automatic test_random();
    logic v, l, r;
    logic [15:0] c;
    step(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) < 2);
      r = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      step(v, 4'($urandom_range(0, 15)), c, l, r, 1'b1);
      checks++; if (out_valid !== exp_valid || overrun !== exp_ovr) begin errors++;
        $display("FAIL rand_flags n=%0d got v=%0b ovr=%0b want v=%0b ovr=%0b", n, out_valid, overrun, exp_valid, exp_ovr); end
      checks++; if (out_c !== exp_c || out_index !== exp_index || out_pos !== exp_pos || out_count !== exp_count) begin errors++;
        $display("FAIL rand_data n=%0d got c=%0d idx=%0d pos=%0d cnt=%0d want c=%0d idx=%0d pos=%0d cnt=%0d",
                 n, out_c, out_index, out_pos, out_count, exp_c, exp_index, exp_pos, exp_count); end
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_index = 4'd0; in_c = 16'd0;
    in_last = 1'b0; out_ready = 1'b0;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_index = 4'd0; exp_c = 16'd0;
    exp_pos = 8'd0; exp_count = 9'd0;
    test_reset();
    test_basic_frame();
    test_single_sample();
    test_full_frame();
    test_overrun();
    test_reset_midframe();
    test_gap_accept();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
